// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: funct3 size encodings, the
// access-width classes they map onto, the FSM state enum, the latched request
// record and the fixed memory transfer size.
// -----------------------------------------------------------------------------
package lsu_pkg;

   // funct3 size encodings from the core; unlisted codes behave as a word
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   // the memory port always moves whole words
   localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      ACC_B = 2'd0,
      ACC_H = 2'd1,
      ACC_W = 2'd2
   } acc_class_e;

   // request captured at accept time
   typedef struct packed {
      logic        write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   // Collapse funct3 into an access width; signedness is bit 2 (0 = signed).
   function automatic acc_class_e size_class(input logic [2:0] sz);
      case (sz)
         SZ_B, SZ_BU: size_class = ACC_B;
         SZ_H, SZ_HU: size_class = ACC_H;
         default:     size_class = ACC_W;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane steering between a memory word and the core.
//   word_in    : word read from memory
//   wdata      : store data from the core (low byte/half used for b/h)
//   offset     : byte address bits [1:0]
//   size       : funct3 size code
//   load_data  : addressed byte/half/word, sign- or zero-extended
//   store_word : word_in with the addressed byte(s) replaced by wdata
// Halves ignore offset[0] and words ignore offset[1:0], so an unaligned
// request that reaches this block is implicitly aligned down.
// -----------------------------------------------------------------------------
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_in,
   input  logic [31:0] wdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  size,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   acc_class_e  cls;
   logic [1:0]  lane;
   logic [4:0]  bit_base;
   logic        sgn;
   logic [31:0] shifted;

   always_comb begin
      cls        = size_class(size);
      sgn        = ~size[2];
      lane       = 2'b00;
      load_data  = word_in;
      store_word = wdata;

      case (cls)
         ACC_B:   lane = offset;
         ACC_H:   lane = {offset[1], 1'b0};
         default: lane = 2'b00;
      endcase

      bit_base = {lane, 3'b000};
      shifted  = word_in >> bit_base;

      case (cls)
         ACC_B: begin
            load_data  = {{24{sgn & shifted[7]}}, shifted[7:0]};
            store_word = word_in;
            store_word[bit_base +: 8] = wdata[7:0];
         end
         ACC_H: begin
            load_data  = {{16{sgn & shifted[15]}}, shifted[15:0]};
            store_word = word_in;
            store_word[bit_base +: 16] = wdata[15:0];
         end
         default: begin
            load_data  = word_in;
            store_word = wdata;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Turns core byte/half/word load/store requests into word-aligned accesses on
// a word-wide data memory port. Sub-word stores are read-modify-write.
//   clk, rst_n          : clock, synchronous active-low reset
//   lsu_req/write/size/addr/wdata : request from execute, sampled in IDLE only
//   lsu_busy            : high while not IDLE (core stalls)
//   lsu_done            : one-cycle completion pulse
//   lsu_rdata           : extended load result, held until the next load
//   lsu_misaligned      : trap flag, valid with lsu_done
//   mem_*               : word-aligned memory port, mem_out is combinational
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// requests complete in one cycle with lsu_misaligned set and no memory access;
// otherwise they are aligned down and performed normally.
// -----------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lsu_req,
   input  logic              lsu_write,
   input  logic [2:0]        lsu_size,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [XLEN-1:0]   lsu_wdata,
   output logic              lsu_busy,
   output logic              lsu_done,
   output logic [XLEN-1:0]   lsu_rdata,
   output logic              lsu_misaligned,
   output logic [31:0]       mem_access_addr,
   output logic [31:0]       mem_in,
   output logic              mem_write_en,
   output logic              mem_read_en,
   output logic [2:0]        mem_data_size,
   input  logic [31:0]       mem_out
);

   lsu_state_e  state_q, state_d;
   lsu_req_t    req_q;
   logic [31:0] wr_word_q;
   logic [31:0] rdata_q;
   logic        mis_q;
   logic        mis_new;
   logic [31:0] ld_data;
   logic [31:0] st_word;

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      mis_new = 1'b0;
      case (size_class(lsu_size))
         ACC_H:   mis_new = lsu_addr[0];
         ACC_W:   mis_new = |lsu_addr[1:0];
         default: mis_new = 1'b0;
      endcase
   end
`else
   assign mis_new = 1'b0;
`endif

   lsu_lane_align u_align (
      .word_in    (mem_out),
      .wdata      (req_q.wdata),
      .offset     (req_q.addr[1:0]),
      .size       (req_q.size),
      .load_data  (ld_data),
      .store_word (st_word)
   );

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (lsu_req) begin
               if (mis_new)
                  state_d = ST_DONE;
               else if (lsu_write && size_class(lsu_size) == ACC_W)
                  state_d = ST_WRITE;
               else
                  state_d = ST_READ;
            end
         end
         ST_READ:  state_d = req_q.write ? ST_WRITE : ST_DONE;
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Every status and strobe is qualified by rst_n so a reset cycle never
   // writes memory or reports a completion, even mid-operation.
   always_comb begin
      lsu_busy       = rst_n & (state_q != ST_IDLE);
      lsu_done       = rst_n & (state_q == ST_DONE);
      lsu_misaligned = rst_n & (state_q == ST_DONE) & mis_q;
      mem_read_en    = rst_n & (state_q == ST_READ);
      mem_write_en   = rst_n & (state_q == ST_WRITE);
   end

   assign mem_access_addr = {req_q.addr[31:2], 2'b00};
   assign mem_in          = wr_word_q;
   assign mem_data_size   = MEM_SIZE_WORD;
   assign lsu_rdata       = XLEN'(rdata_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         wr_word_q <= '0;
         rdata_q   <= '0;
         mis_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && lsu_req) begin
            req_q.write <= lsu_write;
            req_q.size  <= lsu_size;
            req_q.addr  <= 32'(lsu_addr);
            req_q.wdata <= 32'(lsu_wdata);
            // full-word stores go straight out; sub-word ones are
            // overwritten by the merged word in READ
            wr_word_q   <= 32'(lsu_wdata);
            mis_q       <= mis_new;
         end
         if (state_q == ST_READ) begin
            if (req_q.write)
               wr_word_q <= st_word;
            else
               rdata_q   <= ld_data;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed vector table, hand-written corner sequences (misaligned access,
// reset mid-operation, held request) and a random run scored against a
// word-array reference model of memory and the load result.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lsu_req = 1'b0;
   logic        lsu_write = 1'b0;
   logic [2:0]  lsu_size = 3'b0;
   logic [31:0] lsu_addr = 32'h0;
   logic [31:0] lsu_wdata = 32'h0;
   logic        lsu_busy, lsu_done, lsu_misaligned;
   logic [31:0] lsu_rdata;
   logic [31:0] mem_access_addr, mem_in, mem_out;
   logic        mem_write_en, mem_read_en;
   logic [2:0]  mem_data_size;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_req(lsu_req), .lsu_write(lsu_write), .lsu_size(lsu_size),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
      .lsu_misaligned(lsu_misaligned),
      .mem_access_addr(mem_access_addr), .mem_in(mem_in),
      .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
      .mem_data_size(mem_data_size), .mem_out(mem_out)
   );

   // ---------------- environment memory (64 words, bytes 0x00..0xFF) -------
   logic [31:0] mem [64];
   logic        preload = 1'b1;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'h88776655;
      return 32'hA5000000 ^ (32'(i) * 32'h00010203);
   endfunction

   assign mem_out = mem[mem_access_addr[7:2]];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (mem_write_en) begin
         mem[mem_access_addr[7:2]] <= mem_in;
      end
   end

   // ---------------- reference model ---------------------------------------
   logic [31:0] ref_mem [64];
   logic [31:0] last_rd = 32'h0;

   function automatic int cls_of(input logic [2:0] sz);
      if (sz == 3'd0 || sz == 3'd4) return 1;
      if (sz == 3'd1 || sz == 3'd5) return 2;
      return 4;
   endfunction

   function automatic bit ref_mis(input logic [2:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (a % cls_of(sz)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                            input logic [2:0] sz);
      int n = cls_of(sz);
      int off = (a % 4) / n * n;
      logic [31:0] v;
      bit sgn = (sz == 3'd0 || sz == 3'd1);
      if (n == 4) return w;
      v = (w >> (8 * off)) & ((n == 1) ? 32'hFF : 32'hFFFF);
      if (sgn && n == 1 && v >= 32'd128)   v = v + 32'hFFFFFF00;
      if (sgn && n == 2 && v >= 32'd32768) v = v + 32'hFFFF0000;
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] sz, input logic [31:0] wd);
      int n = cls_of(sz);
      int off = (a % 4) / n * n;
      logic [31:0] m;
      if (n == 4) return wd;
      m = ((n == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
      return (w & ~m) | ((wd << (8 * off)) & m);
   endfunction

   // ---------------- helpers -----------------------------------------------
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Issue one request from IDLE and watch it to completion (bounded).
   // lat = number of falling edges after the accept edge until lsu_done (0 = never).
   task automatic do_op(input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic mis, output int nrd, output int nwr,
                        output logic [31:0] raddr, output logic [31:0] wword);
      bit seen = 0;
      lat = 0; nrd = 0; nwr = 0; rd = 'x; mis = 'x; raddr = 'x; wword = 'x;
      @(negedge clk);
      lsu_req = 1'b1; lsu_write = w; lsu_size = sz; lsu_addr = a; lsu_wdata = wd;
      @(posedge clk);
      #1 lsu_req = 1'b0;
      for (int k = 1; k <= 8 && !seen; k++) begin
         @(negedge clk);
         if (mem_read_en)  begin nrd++; raddr = mem_access_addr; end
         if (mem_write_en) begin nwr++; wword = mem_in; end
         if (lsu_done) begin
            seen = 1; lat = k; rd = lsu_rdata; mis = lsu_misaligned;
         end
      end
   endtask

   // ---------------- directed table ----------------------------------------
   typedef struct {
      logic        w;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;     // loads only
      logic [31:0] exp_raddr;  // when a read is expected
      logic [31:0] exp_wword;  // stores only
      int          exp_lat;
      int          exp_nrd;
      int          exp_nwr;
   } vec_t;

   vec_t tbl [13];

   int          lat, nrd, nwr;
   logic [31:0] rd, raddr, wword;
   logic        mis;

   initial begin
      tbl[0]  = '{0, 3'd0, 32'h11, 32'h0,        32'h00000066, 32'h10, 32'h0,        2, 1, 0};
      tbl[1]  = '{0, 3'd0, 32'h13, 32'h0,        32'hFFFFFF88, 32'h10, 32'h0,        2, 1, 0};
      tbl[2]  = '{0, 3'd5, 32'h12, 32'h0,        32'h00008877, 32'h10, 32'h0,        2, 1, 0};
      tbl[3]  = '{0, 3'd1, 32'h12, 32'h0,        32'hFFFF8877, 32'h10, 32'h0,        2, 1, 0};
      tbl[4]  = '{0, 3'd2, 32'h10, 32'h0,        32'h88776655, 32'h10, 32'h0,        2, 1, 0};
      tbl[5]  = '{0, 3'd4, 32'h13, 32'h0,        32'h00000088, 32'h10, 32'h0,        2, 1, 0};
      tbl[6]  = '{1, 3'd0, 32'h12, 32'hFFFFFFAB, 32'h0,        32'h10, 32'h88AB6655, 3, 1, 1};
      tbl[7]  = '{0, 3'd2, 32'h10, 32'h0,        32'h88AB6655, 32'h10, 32'h0,        2, 1, 0};
      tbl[8]  = '{1, 3'd2, 32'h14, 32'hDEADBEEF, 32'h0,        32'h0,  32'hDEADBEEF, 2, 0, 1};
      tbl[9]  = '{0, 3'd2, 32'h14, 32'h0,        32'hDEADBEEF, 32'h14, 32'h0,        2, 1, 0};
      tbl[10] = '{1, 3'd1, 32'h16, 32'hCAFE1234, 32'h0,        32'h14, 32'h1234BEEF, 3, 1, 1};
      tbl[11] = '{0, 3'd2, 32'h14, 32'h0,        32'h1234BEEF, 32'h14, 32'h0,        2, 1, 0};
      tbl[12] = '{0, 3'd0, 32'h15, 32'h0,        32'hFFFFFFBE, 32'h14, 32'h0,        2, 1, 0};

      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

      // ---- reset state, with a request and write asserted during reset ----
      lsu_req = 1'b1; lsu_write = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy",  {31'b0, lsu_busy},       32'h0);
      chk("rst_done",  {31'b0, lsu_done},       32'h0);
      chk("rst_mis",   {31'b0, lsu_misaligned}, 32'h0);
      chk("rst_rdata", lsu_rdata,               32'h0);
      chk("rst_wen",   {31'b0, mem_write_en},   32'h0);
      chk("rst_ren",   {31'b0, mem_read_en},    32'h0);
      chk("rst_memin", mem_in,                  32'h0);
      chk("rst_maddr", mem_access_addr,         32'h0);
      chk("mem_size",  {29'b0, mem_data_size},  32'h2);
      lsu_req = 1'b0; lsu_write = 1'b0; preload = 1'b0; rst_n = 1'b1;

      // ---- table ----
      for (int i = 0; i < 13; i++) begin
         do_op(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, lat, rd, mis, nrd, nwr, raddr, wword);
         chk($sformatf("t%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
         chk($sformatf("t%0d_nrd", i), 32'(nrd), 32'(tbl[i].exp_nrd));
         chk($sformatf("t%0d_nwr", i), 32'(nwr), 32'(tbl[i].exp_nwr));
         chk($sformatf("t%0d_mis", i), {31'b0, mis}, 32'h0);
         if (tbl[i].exp_nrd > 0) chk($sformatf("t%0d_raddr", i), raddr, tbl[i].exp_raddr);
         if (tbl[i].w) begin
            chk($sformatf("t%0d_wword", i), wword, tbl[i].exp_wword);
            ref_mem[tbl[i].a[7:2]] = ref_store(ref_mem[tbl[i].a[7:2]], tbl[i].a, tbl[i].sz, tbl[i].wd);
         end else begin
            chk($sformatf("t%0d_rdata", i), rd, tbl[i].exp_rd);
            last_rd = tbl[i].exp_rd;
         end
      end

      // ---- misaligned lw 0x11 ----
      do_op(1'b0, 3'd2, 32'h11, 32'h0, lat, rd, mis, nrd, nwr, raddr, wword);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_lat",   32'(lat),     32'd1);
      chk("mis_flag",  {31'b0, mis}, 32'h1);
      chk("mis_nrd",   32'(nrd),     32'd0);
      chk("mis_nwr",   32'(nwr),     32'd0);
      chk("mis_rdata", rd,           last_rd);
`else
      chk("unal_lat",   32'(lat),     32'd2);
      chk("unal_flag",  {31'b0, mis}, 32'h0);
      chk("unal_raddr", raddr,        32'h10);
      chk("unal_rdata", rd,           32'h88AB6655);
      last_rd = 32'h88AB6655;
`endif

      // ---- reset during READ of sh 0x1234 to 0x10 ----
      @(negedge clk);
      lsu_req = 1'b1; lsu_write = 1'b1; lsu_size = 3'd1; lsu_addr = 32'h10; lsu_wdata = 32'h1234;
      @(posedge clk);
      #1 lsu_req = 1'b0;
      @(negedge clk);
      chk("ra_in_read", {31'b0, mem_read_en}, 32'h1);
      rst_n = 1'b0;
      #1 chk("ra_wen_rst", {31'b0, mem_write_en}, 32'h0);
      @(negedge clk);
      chk("ra_busy", {31'b0, lsu_busy}, 32'h0);
      rst_n = 1'b1;
      nwr = 0; nrd = 0;
      repeat (4) begin
         @(negedge clk);
         if (mem_write_en) nwr++;
         if (lsu_done)     nrd++;
      end
      chk("ra_nowrite", 32'(nwr), 32'd0);
      chk("ra_nodone",  32'(nrd), 32'd0);
      chk("ra_word",    mem[4],   32'h88AB6655);
      last_rd = 32'h0;  // reset clears the load result

      // ---- request held high through a load ----
      nrd = 0;
      @(negedge clk);
      lsu_req = 1'b1; lsu_write = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h10;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (mem_read_en) nrd++;
         if (k == 2) begin
            chk("hold_done",  {31'b0, lsu_done}, 32'h1);
            chk("hold_rdata", lsu_rdata,         32'h88AB6655);
         end
      end
      chk("hold_one_read", 32'(nrd),            32'd1);
      chk("hold_idle",     {31'b0, lsu_busy},   32'h0);
      @(negedge clk);
      lsu_req = 1'b0;
      chk("hold_2nd_busy", {31'b0, lsu_busy},    32'h1);
      chk("hold_2nd_read", {31'b0, mem_read_en}, 32'h1);
      @(negedge clk);
      chk("hold_2nd_done", {31'b0, lsu_done},    32'h1);
      last_rd = 32'h88AB6655;

      // ---- random run against the reference model ----
      for (int i = 0; i < 300; i++) begin
         logic        w  = 1'($urandom_range(0, 1));
         logic [2:0]  sz = 3'($urandom_range(0, 7));
         logic [31:0] a  = 32'($urandom_range(0, 255));
         logic [31:0] wd = $urandom;
         bit          m  = ref_mis(sz, a);
         int          n  = cls_of(sz);
         int          e_lat = m ? 1 : (w && n != 4) ? 3 : 2;
         int          e_nrd = (m || (w && n == 4)) ? 0 : 1;
         int          e_nwr = (w && !m) ? 1 : 0;
         do_op(w, sz, a, wd, lat, rd, mis, nrd, nwr, raddr, wword);
         chk($sformatf("r%0d_lat", i), 32'(lat), 32'(e_lat));
         chk($sformatf("r%0d_mis", i), {31'b0, mis}, {31'b0, m});
         chk($sformatf("r%0d_nrd", i), 32'(nrd), 32'(e_nrd));
         chk($sformatf("r%0d_nwr", i), 32'(nwr), 32'(e_nwr));
         if (e_nrd > 0) chk($sformatf("r%0d_raddr", i), raddr, a & ~32'h3);
         if (!m && !w) last_rd = ref_load(ref_mem[a[7:2]], a, sz);
         if (!w || m)  chk($sformatf("r%0d_rdata", i), rd, last_rd);
         if (w && !m) begin
            ref_mem[a[7:2]] = ref_store(ref_mem[a[7:2]], a, sz, wd);
            chk($sformatf("r%0d_wword", i), wword, ref_mem[a[7:2]]);
         end
      end

      // ---- final memory image ----
      @(negedge clk);
      for (int i = 0; i < 64; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
